// File: rtl/hazard_ctrl_if.sv
// Decode/EX hazard bundle between the pipeline and hazard_ctrl.
// Stall codes are shared by every block that consumes the stall bus.
`ifndef HAZARD_STALL_DEFS
`define HAZARD_STALL_DEFS
`define STALL_WIDTH  2
`define STALL_NONE   2'b00
`define STALL_LOAD   2'b01
`define STALL_BRANCH 2'b10
`endif

interface hazard_ctrl_if;
    logic [4:0]              id_rs1;
    logic [4:0]              id_rs2;
    logic                    id_rs1_re;
    logic                    id_rs2_re;
    logic                    id_is_branch;
    logic                    id_br_mispredict;
    logic [4:0]              ex_rd;
    logic                    ex_reg_we;
    logic                    ex_mem_read;
    logic [`STALL_WIDTH-1:0] stall;
    logic                    flush;
    logic                    id_ex_bubble;

    modport master (
        output id_rs1, id_rs2, id_rs1_re, id_rs2_re,
        output id_is_branch, id_br_mispredict,
        output ex_rd, ex_reg_we, ex_mem_read,
        input  stall, flush, id_ex_bubble
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_re, id_rs2_re,
        input  id_is_branch, id_br_mispredict,
        input  ex_rd, ex_reg_we, ex_mem_read,
        output stall, flush, id_ex_bubble
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard controller for the IF/ID register,
// with a hold counter for multi-cycle load stalls and saturating perf counters.
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_load_stalls,
    output logic [CNT_W-1:0] perf_branch_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                  state, state_nx;
    logic [2:0]              hold_cnt, hold_cnt_nx;
    logic [`STALL_WIDTH-1:0] hold_code, hold_code_nx;
    logic [`STALL_WIDTH-1:0] stall;
    logic                    flush;
    logic                    rs1_hit, rs2_hit, m;
    logic                    br_load, br_alu, ld_use;

    assign rs1_hit = hz.id_rs1_re && (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit = hz.id_rs2_re && (hz.id_rs2 == hz.ex_rd);
    // x0 is hardwired zero, so a write to it never produces a hazard
    assign m = (rs1_hit || rs2_hit) && hz.ex_reg_we && (hz.ex_rd != 5'd0);

    assign br_load = hz.id_is_branch && m && hz.ex_mem_read;
    assign br_alu  = hz.id_is_branch && m && !hz.ex_mem_read;
    assign ld_use  = !hz.id_is_branch && m && hz.ex_mem_read;

    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        hold_code_nx = hold_code;
        stall        = `STALL_NONE;
        flush        = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    unique case (1'b1)
                        br_load: begin
                            stall        = `STALL_BRANCH;
                            hold_cnt_nx  = 3'(LOAD_LAT);
                            hold_code_nx = `STALL_BRANCH;
                            state_nx     = HOLD;
                        end
                        br_alu: begin
                            stall = `STALL_BRANCH;
                        end
                        ld_use: begin
                            stall = `STALL_LOAD;
                            if (LOAD_LAT > 1) begin
                                hold_cnt_nx  = 3'(LOAD_LAT - 1);
                                hold_code_nx = `STALL_LOAD;
                                state_nx     = HOLD;
                            end
                        end
                        default: begin
                            flush = hz.id_is_branch && hz.id_br_mispredict;
                        end
                    endcase
                end
                HOLD: begin
                    stall       = hold_code;
                    hold_cnt_nx = hold_cnt - 3'd1;
                    if (hold_cnt == 3'd1) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            hold_cnt  <= 3'd0;
            hold_code <= `STALL_NONE;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            hold_code <= hold_code_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || perf_clr) begin
            perf_load_stalls   <= '0;
            perf_branch_stalls <= '0;
            perf_flushes       <= '0;
        end else begin
            if (stall == `STALL_LOAD && perf_load_stalls != '1) begin
                perf_load_stalls <= perf_load_stalls + CNT_W'(1);
            end
            if (stall == `STALL_BRANCH && perf_branch_stalls != '1) begin
                perf_branch_stalls <= perf_branch_stalls + CNT_W'(1);
            end
            if (flush && perf_flushes != '1) begin
                perf_flushes <= perf_flushes + CNT_W'(1);
            end
        end
    end

    assign hz.stall        = stall;
    assign hz.flush        = flush;
    assign hz.id_ex_bubble = (stall != `STALL_NONE);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the IF/ID pipeline register and the ID/EX bubble insertion. It detects load-use and branch-operand hazards for the instruction in Decode and generates the `stall` code and `flush` consumed by the IF/ID register. Multi-cycle stalls are held by an internal down-counter, so the stall persists after the inserted bubble changes the EX-stage inputs. The block also keeps saturating performance counters for stall and flush events, and sits beside the Decode stage.

## Interface
Parameters:
- LOAD_LAT, 1, extra cycles after EX before load data can be forwarded (1–7).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- id_rs1, id_rs2  in  5 each  Decode source register indices.
- id_rs1_re, id_rs2_re  in  1 each  source actually read.
- id_is_branch  in  1  Decode instruction is a branch or jalr, resolved in ID.
- id_br_mispredict  in  1  ID branch unit disagrees with the fetch prediction; meaningful only when `id_is_branch`=1.
- ex_rd  in  5  EX destination register.
- ex_reg_we  in  1  EX instruction writes `ex_rd`.
- ex_mem_read  in  1  EX instruction is a load.
- perf_clr  in  1  synchronous clear of the performance counters.
- stall  out  `STALL_WIDTH  one of `STALL_NONE`, `STALL_LOAD`, `STALL_BRANCH`.
- flush  out  1  zero the instruction entering IF/ID.
- id_ex_bubble  out  1  insert a NOP into ID/EX.
- perf_load_stalls, perf_branch_stalls, perf_flushes  out  CNT_W each  event counters.

## Operation
- Source match: `m` = (id_rs1_re && id_rs1==ex_rd) || (id_rs2_re && id_rs2==ex_rd), qualified by ex_reg_we && ex_rd!=0.
- FSM states:
  - IDLE: hazard decode is combinational from the inputs.
  - HOLD: stall is forced from registers; the inputs are ignored.
- In IDLE, evaluate in priority order:
  1. Branch-on-load: id_is_branch && m && ex_mem_read.
     - stall=`STALL_BRANCH`.
     - Load hold_cnt=LOAD_LAT and hold_code=BRANCH.
     - Go to HOLD.
     - Total stall = LOAD_LAT+1 cycles.
  2. Branch-on-ALU: id_is_branch && m && !ex_mem_read.
     - stall=`STALL_BRANCH` for 1 cycle.
     - Stay in IDLE.
  3. Load-use: !id_is_branch && m && ex_mem_read.
     - stall=`STALL_LOAD`.
     - If LOAD_LAT>1: load hold_cnt=LOAD_LAT-1 and hold_code=LOAD, then go to HOLD.
     - Otherwise stay in IDLE.
     - Total stall = LOAD_LAT cycles.
  4. Otherwise stall=`STALL_NONE`.
- HOLD:
  - stall = hold_code.
  - hold_cnt decrements each cycle.
  - Return to IDLE on the cycle hold_cnt goes 1→0.
  - The hazard is then re-evaluated fresh in IDLE.
- flush=1 only when state=IDLE && stall=`STALL_NONE` && id_is_branch && id_br_mispredict.
  - A mispredict signalled while stalled is ignored; the branch re-resolves after the stall.
- id_ex_bubble = (stall != `STALL_NONE`).
- Counters count per cycle, saturate at all-ones, and never wrap:
  - perf_load_stalls: +1 per cycle with stall=`STALL_LOAD`.
  - perf_branch_stalls: +1 per cycle with stall=`STALL_BRANCH`.
  - perf_flushes: +1 per flush cycle.
- perf_clr has priority over increment. The stall/flush outputs are unaffected by perf_clr.

## Timing
- Reset (rst=0 at posedge):
  - state=IDLE, hold_cnt=0, all counters=0.
  - While rst=0: stall=`STALL_NONE`, flush=0, id_ex_bubble=0, regardless of inputs.
- Reset mid-HOLD aborts the stall. The first cycle after reset is IDLE.
- Combinational path from inputs to stall/flush in IDLE; zero-cycle detection latency.
- HOLD outputs depend only on registers.
- Counters reflect an event on the posedge that closes the event cycle (1-cycle lag).
- Register x0 never creates a hazard.
- stall and flush are never both 1.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_re=1, LOAD_LAT=1.
  - stall=`STALL_LOAD` for exactly 1 cycle.
  - id_ex_bubble=1 for that cycle.
  - perf_load_stalls=1.
- Branch-on-load, LOAD_LAT=2: id_is_branch=1, match on a load.
  - stall=`STALL_BRANCH` for 3 consecutive cycles even after ex_mem_read drops to 0.
  - Then `STALL_NONE`.
  - perf_branch_stalls=3.
- Branch-on-ALU: id_is_branch=1, ex_reg_we=1, ex_mem_read=0, match.
  - 1 stall cycle.
  - Next cycle id_br_mispredict=1 gives flush=1 for 1 cycle and perf_flushes=1.
- x0 and unused sources: ex_rd=0, or rs match with id_rs*_re=0.
  - stall=`STALL_NONE` throughout.
- Reset: assert rst=0 during HOLD.
  - Outputs go to NONE/0 and counters to 0.
  - After release, a mispredict with no hazard flushes immediately.
- Saturation: force counter to all-ones-1, then 3 load stalls.
  - Counter holds all-ones.
  - perf_clr returns it to 0.
